// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter.
// Request and response valid/ready channels for two requesters.
interface alu_share_arbiter_if;
   logic [1:0]  ReqValid;
   logic [1:0]  ReqReady;
   logic [11:0] ReqOp;
   logic [63:0] ReqA;
   logic [63:0] ReqB;
   logic [1:0]  RspValid;
   logic [1:0]  RspReady;
   logic [31:0] RspResult;
   logic        RspZero;

   modport master (
      output ReqValid, ReqOp, ReqA, ReqB, RspReady,
      input  ReqReady, RspValid, RspResult, RspZero
   );

   modport slave (
      input  ReqValid, ReqOp, ReqA, ReqB, RspReady,
      output ReqReady, RspValid, RspResult, RspZero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU32Bit between two requesters.
// Operands are held for the whole operation; the result waits for its owner.
module alu_share_arbiter #(
   parameter int unsigned MUL_LAT = 2,
   parameter logic [5:0]  MUL_OP  = 6'b011000
) (
   input  logic                Clk,
   input  logic                Rst,
   alu_share_arbiter_if.slave  bus,
   output logic [5:0]          ALUControl,
   output logic [31:0]         ALU_A,
   output logic [31:0]         ALU_B,
   input  logic [31:0]         ALUResult,
   input  logic                ALUZero,
   output logic                Busy
);

   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t        state;
   logic          last;
   logic          owner;
   logic [CW-1:0] cnt;
   logic [1:0]    rsp_valid;
   logic [31:0]   rsp_result;
   logic          rsp_zero;

   logic          gsel;
   logic [1:0]    grant;
   logic [5:0]    sel_op;
   logic [31:0]   sel_a;
   logic [31:0]   sel_b;

   // Pick the winner; ready is only offered while idle and out of reset.
   always_comb begin
      gsel   = bus.ReqValid[1] & (~bus.ReqValid[0] | ~last);
      grant  = 2'b00;
      if (state == IDLE && Rst)
         grant = (gsel ? 2'b10 : 2'b01) & bus.ReqValid;
      sel_op = gsel ? bus.ReqOp[11:6] : bus.ReqOp[5:0];
      sel_a  = gsel ? bus.ReqA[63:32] : bus.ReqA[31:0];
      sel_b  = gsel ? bus.ReqB[63:32] : bus.ReqB[31:0];
   end

   // Operation sequencer: accept, hold operands, capture, hand back.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         owner      <= 1'b0;
         cnt        <= '0;
         rsp_valid  <= 2'b00;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         ALUControl <= '0;
         ALU_A      <= '0;
         ALU_B      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|grant) begin
                  ALUControl <= sel_op;
                  ALU_A      <= sel_a;
                  ALU_B      <= sel_b;
                  owner      <= gsel;
                  cnt        <= (sel_op == MUL_OP) ? CNT_MUL : '0;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_result <= ALUResult;
                  rsp_zero   <= ALUZero;
                  rsp_valid  <= owner ? 2'b10 : 2'b01;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_valid[owner] && bus.RspReady[owner]) begin
                  last      <= owner;
                  rsp_valid <= 2'b00;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ReqReady  = grant;
   assign bus.RspValid  = rsp_valid;
   assign bus.RspResult = rsp_result;
   assign bus.RspZero   = rsp_zero;
   assign Busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU stub.
// Runs with MUL_LAT=3 so the multiply hold window is visible.
module tb_alu_share_arbiter;

   localparam int unsigned MUL_LAT = 3;
   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_MUL = 6'b011000;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [5:0]  ALUControl;
   logic [31:0] ALU_A;
   logic [31:0] ALU_B;
   logic [31:0] ALUResult;
   logic        ALUZero;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter_if bus();

   alu_share_arbiter #(
      .MUL_LAT (MUL_LAT),
      .MUL_OP  (OP_MUL)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .bus        (bus),
      .ALUControl (ALUControl),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALUResult  (ALUResult),
      .ALUZero    (ALUZero),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   // ALU stand-in: enough opcodes for the directed vectors.
   always_comb begin
      case (ALUControl)
         OP_ADD:  ALUResult = ALU_A + ALU_B;
         OP_SUB:  ALUResult = ALU_A - ALU_B;
         OP_MUL:  ALUResult = ALU_A * ALU_B;
         default: ALUResult = 32'hDEAD_BEEF;
      endcase
   end
   assign ALUZero = (ALUResult == 32'd0);

   task automatic idle_inputs();
      bus.ReqValid = 2'b00;
      bus.ReqOp    = '0;
      bus.ReqA     = '0;
      bus.ReqB     = '0;
      bus.RspReady = 2'b00;
   endtask

   task automatic issue(input int r, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.ReqOp[5:0]  = op;
         bus.ReqA[31:0]  = a;
         bus.ReqB[31:0]  = b;
         bus.ReqValid[0] = 1'b1;
      end else begin
         bus.ReqOp[11:6]  = op;
         bus.ReqA[63:32]  = a;
         bus.ReqB[63:32]  = b;
         bus.ReqValid[1]  = 1'b1;
      end
   endtask

   // Edges after the current one until RspValid shows; -1 on timeout.
   task automatic wait_rsp(output int n);
      n = 0;
      while (bus.RspValid == 2'b00 && n < 20) begin
         @(posedge Clk);
         n++;
         @(negedge Clk);
      end
      if (bus.RspValid == 2'b00) n = -1;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      #2 Rst = 1'b0;
      bus.ReqValid = 2'b11;
      bus.ReqOp    = 12'($urandom);
      bus.ReqA     = {$urandom, $urandom};
      bus.ReqB     = {$urandom, $urandom};
      bus.RspReady = 2'($urandom);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (bus.ReqReady !== 2'b00) begin
         errors++; $display("FAIL rst_reqready got %b want 00", bus.ReqReady);
      end
      checks++;
      if (bus.RspValid !== 2'b00) begin
         errors++; $display("FAIL rst_rspvalid got %b want 00", bus.RspValid);
      end
      checks++;
      if (bus.RspResult !== 32'd0 || bus.RspZero !== 1'b0) begin
         errors++;
         $display("FAIL rst_rsp got %h/%b want 0/0", bus.RspResult, bus.RspZero);
      end
      checks++;
      if (ALUControl !== 6'd0 || ALU_A !== 32'd0 || ALU_B !== 32'd0) begin
         errors++;
         $display("FAIL rst_alu got %h %h %h want 0", ALUControl, ALU_A, ALU_B);
      end
      checks++;
      if (Busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy got %b want 0", Busy);
      end
      idle_inputs();
      Rst = 1'b1;
   endtask

   task automatic test_add();
      int n;
      bus.RspReady = 2'b11;
      issue(0, OP_ADD, 32'h0A, 32'h05);
      #1;
      checks++;
      if (bus.ReqReady !== 2'b01) begin
         errors++; $display("FAIL add_ready got %b want 01", bus.ReqReady);
      end
      @(posedge Clk);
      @(negedge Clk);
      bus.ReqValid = 2'b00;
      checks++;
      if (Busy !== 1'b1 || bus.RspValid !== 2'b00) begin
         errors++;
         $display("FAIL add_exec got busy=%b rv=%b want 1/00", Busy, bus.RspValid);
      end
      wait_rsp(n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL add_latency got %0d want 1", n);
      end
      checks++;
      if (bus.RspValid !== 2'b01 || bus.RspResult !== 32'h0F || bus.RspZero !== 1'b0) begin
         errors++;
         $display("FAIL add_rsp got %b %h %b want 01 0000000f 0",
                  bus.RspValid, bus.RspResult, bus.RspZero);
      end
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (bus.RspValid !== 2'b00 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL add_done got rv=%b busy=%b want 00/0", bus.RspValid, Busy);
      end
   endtask

   task automatic test_sub();
      int n;
      bus.RspReady = 2'b11;
      issue(1, OP_SUB, 32'd5, 32'd5);
      #1;
      checks++;
      if (bus.ReqReady !== 2'b10) begin
         errors++; $display("FAIL sub_ready got %b want 10", bus.ReqReady);
      end
      @(posedge Clk);
      @(negedge Clk);
      bus.ReqValid = 2'b00;
      wait_rsp(n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL sub_latency got %0d want 1", n);
      end
      checks++;
      if (bus.RspValid !== 2'b10 || bus.RspResult !== 32'd0 || bus.RspZero !== 1'b1) begin
         errors++;
         $display("FAIL sub_rsp got %b %h %b want 10 00000000 1",
                  bus.RspValid, bus.RspResult, bus.RspZero);
      end
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (bus.RspValid !== 2'b00) begin
         errors++; $display("FAIL sub_done got %b want 00", bus.RspValid);
      end
   endtask

   task automatic test_mul();
      int n;
      bus.RspReady = 2'b11;
      issue(0, OP_MUL, 32'h0A, 32'h05);
      #1;
      checks++;
      if (bus.ReqReady !== 2'b01) begin
         errors++; $display("FAIL mul_ready got %b want 01", bus.ReqReady);
      end
      @(posedge Clk);
      @(negedge Clk);
      bus.ReqValid = 2'b00;
      n = 0;
      while (bus.RspValid == 2'b00 && n < 20) begin
         checks++;
         if (ALUControl !== OP_MUL || ALU_A !== 32'h0A || ALU_B !== 32'h05) begin
            errors++;
            $display("FAIL mul_hold got %b %h %h want 011000 0000000a 00000005",
                     ALUControl, ALU_A, ALU_B);
         end
         @(posedge Clk);
         n++;
         @(negedge Clk);
      end
      checks++;
      if (n !== 3) begin
         errors++; $display("FAIL mul_latency got %0d want 3", n);
      end
      checks++;
      if (bus.RspValid !== 2'b01 || bus.RspResult !== 32'h32) begin
         errors++;
         $display("FAIL mul_rsp got %b %h want 01 00000032",
                  bus.RspValid, bus.RspResult);
      end
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (bus.RspValid !== 2'b00) begin
         errors++; $display("FAIL mul_done got %b want 00", bus.RspValid);
      end
   endtask

   task automatic test_alternate();
      logic [1:0] gv [8];
      int gcyc [8];
      int ng;
      logic [1:0] want;
      ng = 0;
      Rst = 1'b0;
      #2 Rst = 1'b1;
      bus.ReqOp    = {OP_SUB, OP_ADD};
      bus.ReqA     = {32'd9, 32'd1};
      bus.ReqB     = {32'd4, 32'd2};
      bus.ReqValid = 2'b11;
      bus.RspReady = 2'b11;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (bus.ReqReady != 2'b00 && ng < 8) begin
            gv[ng]   = bus.ReqReady;
            gcyc[ng] = c;
            ng++;
         end
         if (bus.RspValid == 2'b01) begin
            checks++;
            if (bus.RspResult !== 32'd3) begin
               errors++; $display("FAIL alt_rsp0 got %h want 00000003", bus.RspResult);
            end
         end
         if (bus.RspValid == 2'b10) begin
            checks++;
            if (bus.RspResult !== 32'd5) begin
               errors++; $display("FAIL alt_rsp1 got %h want 00000005", bus.RspResult);
            end
         end
         @(posedge Clk);
         @(negedge Clk);
      end
      bus.ReqValid = 2'b00;
      checks++;
      if (ng !== 4) begin
         errors++; $display("FAIL alt_count got %0d want 4", ng);
      end
      for (int k = 0; k < 4 && k < ng; k++) begin
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (gv[k] !== want || gcyc[k] !== 3 * k) begin
            errors++;
            $display("FAIL alt_grant%0d got %b@%0d want %b@%0d",
                     k, gv[k], gcyc[k], want, 3 * k);
         end
      end
   endtask

   task automatic test_hold_reset();
      int n;
      bus.RspReady = 2'b10;
      issue(0, OP_ADD, 32'h10, 32'h20);
      #1;
      checks++;
      if (bus.ReqReady !== 2'b01) begin
         errors++; $display("FAIL hold_ready got %b want 01", bus.ReqReady);
      end
      @(posedge Clk);
      @(negedge Clk);
      bus.ReqValid = 2'b00;
      issue(1, OP_SUB, 32'd7, 32'd2);
      wait_rsp(n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL hold_latency got %0d want 1", n);
      end
      repeat (5) begin
         #1;
         checks++;
         if (bus.RspValid !== 2'b01 || bus.RspResult !== 32'h30 ||
             bus.ReqReady !== 2'b00) begin
            errors++;
            $display("FAIL hold_stall got rv=%b res=%h rr=%b want 01 00000030 00",
                     bus.RspValid, bus.RspResult, bus.ReqReady);
         end
         @(posedge Clk);
         @(negedge Clk);
      end
      bus.RspReady = 2'b11;
      @(posedge Clk);
      @(negedge Clk);
      #1;
      checks++;
      if (bus.RspValid !== 2'b00 || bus.ReqReady !== 2'b10) begin
         errors++;
         $display("FAIL hold_release got rv=%b rr=%b want 00/10",
                  bus.RspValid, bus.ReqReady);
      end
      @(posedge Clk);
      @(negedge Clk);
      bus.ReqValid = 2'b00;
      checks++;
      if (Busy !== 1'b1) begin
         errors++; $display("FAIL hold_exec got busy=%b want 1", Busy);
      end
      Rst = 1'b0;
      #1;
      checks++;
      if (Busy !== 1'b0 || bus.RspValid !== 2'b00 || ALU_A !== 32'd0) begin
         errors++;
         $display("FAIL midreset got busy=%b rv=%b a=%h want 0/00/0",
                  Busy, bus.RspValid, ALU_A);
      end
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (4) begin
         @(posedge Clk);
         @(negedge Clk);
         checks++;
         if (bus.RspValid !== 2'b00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rv=%b busy=%b want 00/0",
                     bus.RspValid, Busy);
         end
      end
   endtask

   initial begin
      idle_inputs();
      Rst = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_alternate();
      test_hold_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
